univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register: the next generation of our fixed 4-bit parallel-in/parallel-out register. It adds configurable width, enable-gated shift, rotate and arithmetic modes, and serial in/out on both ends. It also has a built-in burst serialiser (start/busy/done) that loads a word and shifts it out MSB-first without per-cycle mode control. It sits between parallel datapaths and serial links or bit-level test logic.

Parameters:
WIDTH, 4, register width in bits; legal range WIDTH >= 2.
CNT_W, $clog2(WIDTH+1), burst counter width; derived, not overridden.

Ports:
clk  input  1  single clock; all state updates on rising edge.
clear  input  1  synchronous, active-high reset.
en  input  1  enables mode operations and stalls burst shifting when low.
mode  input  3  operation select (see Behaviour); ignored while busy.
pi  input  WIDTH  parallel data in.
sin_l  input  1  serial in at MSB end (right shifts).
sin_r  input  1  serial in at LSB end (left shifts and burst fill).
start  input  1  burst request; accepted only when busy=0.
po  output  WIDTH  register contents (registered).
sout_msb  output  1  equals po[WIDTH-1] (combinational from register).
sout_lsb  output  1  equals po[0] (combinational from register).
busy  output  1  high while burst in progress (registered).
done  output  1  one-cycle pulse at burst completion (registered).

Behaviour:
- Reset: clear=1 at an edge -> po=0, busy=0, done=0, counter=0. Overrides everything else, including an active burst.
- Priority per edge: clear > burst shift (busy=1) > start accept (busy=0) > mode operation (en=1).
- done defaults to 0 every cycle unless set by burst completion.
- Mode encoding, applied when busy=0, start=0, en=1:
  - 000 hold.
  - 001 parallel load: po <= pi.
  - 010 shift left: po <= {po[WIDTH-2:0], sin_r}.
  - 011 shift right: po <= {sin_l, po[WIDTH-1:1]}.
  - 100 rotate left: po <= {po[WIDTH-2:0], po[WIDTH-1]}.
  - 101 rotate right: po <= {po[0], po[WIDTH-1:1]}.
  - 110 arithmetic shift right: po <= {po[WIDTH-1], po[WIDTH-1:1]}.
  - 111 clear-to-zero: po <= 0.
- en=0 with busy=0 and start=0 -> hold, for all modes.
- Burst state machine, states IDLE (busy=0) and SHIFT (busy=1):
  - IDLE, start=1 at edge k: po <= pi, counter <= 0, busy <= 1. Not gated by en. mode is ignored on this edge.
  - SHIFT, en=1: po <= {po[WIDTH-2:0], sin_r}, counter++.
  - SHIFT, en=0: full stall; po, counter and busy hold.
  - The edge on which counter reaches WIDTH (the WIDTH-th shift): busy <= 0, done <= 1, counter <= 0.
  - With en held high, done is high in the cycle after edge k+WIDTH.
  - sout_msb presents bits pi[WIDTH-1]..pi[0] in the cycles following edges k..k+WIDTH-1.
  - start while busy=1 is ignored; no queueing.
  - start=1 in the cycle done=1 is accepted (busy=0), giving back-to-back bursts with no gap.
- clear mid-burst aborts: busy=0, done is not pulsed, po=0.

Test Plan:
- Reset, then mode=001, pi=1001, en=1, one edge -> po=1001, busy=0, done=0.
- po=1001, mode=010, sin_r=1, one edge -> po=0011. Then mode=101, one edge -> po=1001. Then mode=110, po preset to 1010 -> 1101.
- po=1011, en=0, mode=010 for 3 edges -> po stays 1011. Then mode=100, en=1 -> 0111.
- start=1 with pi=1011, en=1, sin_r=0 -> busy=1; sout_msb reads 1,0,1,1 over 4 cycles; done=1 for exactly one cycle at edge start+4; po=0000 afterwards.
- Burst with en=0 for 2 cycles mid-stream -> done is delayed by 2 cycles and bit order is intact. A second start during busy has no effect.
- clear=1 two edges after start -> next cycle po=0, busy=0, done never pulses. A fresh start after that is accepted normally.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, shift/rotate/arithmetic modes, serial
// in/out at both ends, and a start/busy/done burst serialiser that shifts MSB-first.
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pi,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  output logic [WIDTH-1:0] po,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] po_nxt;
  logic             done_nxt;

  // State register: clear wins over everything, including an active burst
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      po    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      po    <= po_nxt;
      done  <= done_nxt;
    end
  end

  // Next state: burst shifting, then start accept, then the en-gated mode ops
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    po_nxt    = po;
    done_nxt  = 1'b0;
    case (state)
      SHIFT: begin
        if (en) begin
          po_nxt = {po[WIDTH-2:0], sin_r};
          // The WIDTH-th shift finishes the burst; counter returns to 0 here
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        if (start) begin
          po_nxt    = pi;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end else if (en) begin
          case (mode)
            3'b001:  po_nxt = pi;
            3'b010:  po_nxt = {po[WIDTH-2:0], sin_r};
            3'b011:  po_nxt = {sin_l, po[WIDTH-1:1]};
            3'b100:  po_nxt = {po[WIDTH-2:0], po[WIDTH-1]};
            3'b101:  po_nxt = {po[0], po[WIDTH-1:1]};
            3'b110:  po_nxt = {po[WIDTH-1], po[WIDTH-1:1]};
            3'b111:  po_nxt = '0;
            default: po_nxt = po;
          endcase
        end
      end
    endcase
  end

  assign busy     = (state == SHIFT);
  assign sout_msb = po[WIDTH-1];
  assign sout_lsb = po[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=4): mode operations, en gating,
// burst serialisation with stalls, back-to-back bursts and clear abort.
module tb_univ_shift_reg;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             clear, en, sin_l, sin_r, start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] pi;
  logic [WIDTH-1:0] po;
  logic             sout_msb, sout_lsb, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .clear    (clear),
    .en       (en),
    .mode     (mode),
    .pi       (pi),
    .sin_l    (sin_l),
    .sin_r    (sin_r),
    .start    (start),
    .po       (po),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks po, busy and done together
  task automatic chk3(input string tag, input logic [WIDTH-1:0] e_po,
                      input logic e_busy, input logic e_done);
    chk({tag, ".po"}, 32'(po), 32'(e_po));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  initial begin
    clear = 1'b1; en = 1'b0; mode = 3'b000; pi = '0;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0;
    step();
    chk3("reset", 4'b0000, 1'b0, 1'b0);
    chk("reset.sout_msb", 32'(sout_msb), 32'd0);

    // Mode operations
    clear = 1'b0; en = 1'b1; mode = 3'b001; pi = 4'b1001;
    step();
    chk3("load", 4'b1001, 1'b0, 1'b0);
    chk("load.sout_msb", 32'(sout_msb), 32'd1);
    chk("load.sout_lsb", 32'(sout_lsb), 32'd1);

    mode = 3'b010; sin_r = 1'b1;
    step();
    chk("shl", 32'(po), 32'(4'b0011));

    mode = 3'b101;
    step();
    chk("rotr", 32'(po), 32'(4'b1001));

    mode = 3'b001; pi = 4'b1010;
    step();
    mode = 3'b110;
    step();
    chk("asr", 32'(po), 32'(4'b1101));

    mode = 3'b011; sin_l = 1'b0;
    step();
    chk("shr", 32'(po), 32'(4'b0110));

    mode = 3'b011; sin_l = 1'b1;
    step();
    chk("shr_sin1", 32'(po), 32'(4'b1011));

    // en low holds for every mode
    en = 1'b0; mode = 3'b010;
    step(); step(); step();
    chk("en0_hold", 32'(po), 32'(4'b1011));

    en = 1'b1; mode = 3'b100;
    step();
    chk("rotl", 32'(po), 32'(4'b0111));

    mode = 3'b000;
    step();
    chk("hold", 32'(po), 32'(4'b0111));

    mode = 3'b111;
    step();
    chk("zero", 32'(po), 32'(4'b0000));

    // Burst of 1011, mode set to clear-to-zero to show it is ignored on start
    mode = 3'b111; pi = 4'b1011; sin_r = 1'b0; start = 1'b1;
    step();
    chk3("b1.k", 4'b1011, 1'b1, 1'b0);
    chk("b1.bit3", 32'(sout_msb), 32'd1);
    start = 1'b0; mode = 3'b000;
    step();
    chk3("b1.k1", 4'b0110, 1'b1, 1'b0);
    chk("b1.bit2", 32'(sout_msb), 32'd0);
    step();
    chk("b1.bit1", 32'(sout_msb), 32'd1);
    step();
    chk3("b1.k3", 4'b1000, 1'b1, 1'b0);
    chk("b1.bit0", 32'(sout_msb), 32'd1);
    step();
    chk3("b1.done", 4'b0000, 1'b0, 1'b1);
    step();
    chk3("b1.after", 4'b0000, 1'b0, 1'b0);

    // Burst of 1101 with a two-cycle stall and an ignored start
    pi = 4'b1101; start = 1'b1;
    step();
    chk3("b2.k", 4'b1101, 1'b1, 1'b0);
    start = 1'b0;
    step();
    chk("b2.bit2", 32'(sout_msb), 32'd1);
    en = 1'b0; start = 1'b1; pi = 4'b0000;
    step();
    chk3("b2.stall1", 4'b1010, 1'b1, 1'b0);
    step();
    chk3("b2.stall2", 4'b1010, 1'b1, 1'b0);
    en = 1'b1; start = 1'b0;
    step();
    chk3("b2.k4", 4'b0100, 1'b1, 1'b0);
    chk("b2.bit1", 32'(sout_msb), 32'd0);
    step();
    chk3("b2.k5", 4'b1000, 1'b1, 1'b0);
    step();
    chk3("b2.done", 4'b0000, 1'b0, 1'b1);

    // Start in the done cycle: back-to-back, then clear two edges in
    start = 1'b1; pi = 4'b0110;
    step();
    chk3("b3.k", 4'b0110, 1'b1, 1'b0);
    start = 1'b0;
    step();
    chk3("b3.k1", 4'b1100, 1'b1, 1'b0);
    clear = 1'b1;
    step();
    chk3("b3.clear", 4'b0000, 1'b0, 1'b0);
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("b3.no_done", 32'(done), 32'd0);
      chk("b3.idle", 32'(busy), 32'd0);
    end

    // Fresh burst after abort
    pi = 4'b1001; start = 1'b1;
    step();
    chk3("b4.k", 4'b1001, 1'b1, 1'b0);
    start = 1'b0;
    step(); step(); step();
    chk3("b4.k3", 4'b1000, 1'b1, 1'b0);
    step();
    chk3("b4.done", 4'b0000, 1'b0, 1'b1);
    step();
    chk("b4.done_pulse", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
